// File: rtl/ccr_unit_if.sv
// Bus bundle for the condition-code unit: flagged ALU input, stack and
// condition-request controls, and the registered status/response outputs.
interface ccr_unit_if #(
  parameter int CNT_W = 3
);
  logic [35:0]      alu_out;
  logic             ccr_load;
  logic             flag_push;
  logic             flag_pop;
  logic             cond_req;
  logic [3:0]       cond_code;
  logic [3:0]       flags;
  logic             cond_valid;
  logic             cond_true;
  logic [CNT_W-1:0] stack_count;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  // Producer side: drives the ALU bus and the control requests.
  modport master (
    output alu_out, ccr_load, flag_push, flag_pop, cond_req, cond_code,
    input  flags, cond_valid, cond_true, stack_count, stack_full,
           stack_empty, stack_err
  );

  // Condition-code unit side.
  modport slave (
    input  alu_out, ccr_load, flag_push, flag_pop, cond_req, cond_code,
    output flags, cond_valid, cond_true, stack_count, stack_full,
           stack_empty, stack_err
  );
endinterface

// File: rtl/ccr_unit.sv
// Condition-code register with a 16-way branch-condition evaluator
// (registered, one-cycle latency) and a small flag save/restore stack
// used on exception entry and return.
module ccr_unit #(
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 3
) (
  input logic         clk,
  input logic         reset,
  ccr_unit_if.slave   bus
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [3:0]       flag_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             true_q;
  logic             err_q;
  logic [3:0]       stack_mem [STACK_DEPTH];

  logic             full;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;
  logic             op_err;
  logic [CNT_W-1:0] top_cnt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             cond_eval;
  logic             unused_result;

  // The 32-bit result field rides along on the bus but carries no flag info.
  assign unused_result = ^bus.alu_out[31:0];

  assign full    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign top_cnt = count_q - CNT_W'(1);
  assign wr_idx  = count_q[IDX_W-1:0];
  assign rd_idx  = top_cnt[IDX_W-1:0];

  // Simultaneous push and pop is ambiguous, so both are refused.
  assign push_ok = bus.flag_push & ~bus.flag_pop & ~full;
  assign pop_ok  = bus.flag_pop & ~bus.flag_push & ~empty;
  assign op_err  = (bus.flag_push & bus.flag_pop)
                 | (bus.flag_push & ~bus.flag_pop & full)
                 | (bus.flag_pop & ~bus.flag_push & empty);

  // Evaluate the selected branch condition against the current (pre-edge) flags.
  always_comb begin
    // NOTE: default first so every path assigns cond_eval and no latch is inferred.
    cond_eval = 1'b0;
    case (bus.cond_code)
      4'h0: cond_eval = flag_q[2];
      4'h1: cond_eval = ~flag_q[2];
      4'h2: cond_eval = flag_q[1];
      4'h3: cond_eval = ~flag_q[1];
      4'h4: cond_eval = flag_q[3];
      4'h5: cond_eval = ~flag_q[3];
      4'h6: cond_eval = flag_q[0];
      4'h7: cond_eval = ~flag_q[0];
      4'h8: cond_eval = flag_q[1] & ~flag_q[2];
      4'h9: cond_eval = ~flag_q[1] | flag_q[2];
      4'hA: cond_eval = (flag_q[3] == flag_q[0]);
      4'hB: cond_eval = (flag_q[3] != flag_q[0]);
      4'hC: cond_eval = ~flag_q[2] & (flag_q[3] == flag_q[0]);
      4'hD: cond_eval = flag_q[2] | (flag_q[3] != flag_q[0]);
      4'hE: cond_eval = 1'b1;
      4'hF: cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  end

  // Flag register: a legal pop restores the stack top and beats a load.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      flag_q <= 4'h0;
    end else if (pop_ok) begin
      flag_q <= stack_mem[rd_idx];
    end else if (bus.ccr_load) begin
      flag_q <= bus.alu_out[35:32];
    end
  end

  // Stack occupancy and the one-cycle illegal-operation pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= op_err;
      if (push_ok) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_ok) begin
        count_q <= top_cnt;
      end
    end
  end

  // Stack storage; saves the flags as they were before this edge.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count alone says what is valid.
    if (push_ok) begin
      stack_mem[wr_idx] <= flag_q;
    end
  end

  // Registered condition response; cond_true holds between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      true_q  <= 1'b0;
    end else begin
      valid_q <= bus.cond_req;
      if (bus.cond_req) begin
        true_q <= cond_eval;
      end
    end
  end

  assign bus.flags       = flag_q;
  assign bus.cond_valid  = valid_q;
  assign bus.cond_true   = true_q;
  assign bus.stack_count = count_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model.
module tb_ccr_unit;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  ccr_unit_if #(.CNT_W(3)) bus ();

  ccr_unit #(.STACK_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [3:0] m_flags;
  logic [3:0] m_stack [$];
  logic       m_valid;
  logic       m_true;
  logic       m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All 16 condition outcomes as a vector, indexed by the code.
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic [15:0] t;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    t = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v),
         ~c | z, c & ~z, ~v, v, ~n, n, ~c, c, ~z, z};
    return t[code];
  endfunction

  task automatic model_reset();
    m_flags = 4'h0;
    m_stack.delete();
    m_valid = 1'b0;
    m_true  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.alu_out   = 36'h0;
    bus.ccr_load  = 1'b0;
    bus.flag_push = 1'b0;
    bus.flag_pop  = 1'b0;
    bus.cond_req  = 1'b0;
    bus.cond_code = 4'h0;
  endtask

  // One clock: drive inputs, advance the model, let the edge pass, idle inputs.
  task automatic cyc(input logic ld, input logic [3:0] nf, input logic pu,
                     input logic po, input logic rq, input logic [3:0] cc);
    logic [3:0] nxt;
    logic       popped;
    bus.alu_out   = {nf, 32'($urandom)};
    bus.ccr_load  = ld;
    bus.flag_push = pu;
    bus.flag_pop  = po;
    bus.cond_req  = rq;
    bus.cond_code = cc;
    nxt    = m_flags;
    popped = 1'b0;
    m_err  = 1'b0;
    if (rq) begin
      m_true  = ref_cond(cc, m_flags);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (pu && po) begin
      m_err = 1'b1;
    end else if (pu) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back(m_flags);
    end else if (po) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else begin
        nxt    = m_stack.pop_back();
        popped = 1'b1;
      end
    end
    if (!popped && ld) nxt = nf;
    m_flags = nxt;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", bus.flags); end
    checks++; if (bus.cond_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.cond_valid); end
    checks++; if (bus.cond_true !== 1'b0) begin errors++; $display("FAIL reset_true: got %b want 0", bus.cond_true); end
    checks++; if (bus.stack_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.stack_count); end
    checks++; if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b want 10", bus.stack_empty, bus.stack_full); end
    checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.stack_err); end
    #4 reset = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hE);
    checks++; if (bus.cond_valid !== 1'b1 || bus.cond_true !== 1'b1) begin errors++; $display("FAIL reset_al: got v=%b t=%b want v=1 t=1", bus.cond_valid, bus.cond_true); end
  endtask

  task automatic test_load_eval();
    logic [3:0] codes [4];
    logic       want [4];
    codes = '{4'h0, 4'h1, 4'h9, 4'h8};
    want  = '{1'b1, 1'b0, 1'b1, 1'b0};
    cyc(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (bus.flags !== 4'b0100) begin errors++; $display("FAIL load_flags: got %b want 0100", bus.flags); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, codes[i]);
      checks++;
      if (bus.cond_valid !== 1'b1 || bus.cond_true !== want[i] || want[i] !== m_true) begin
        errors++;
        $display("FAIL load_eval code %h: got v=%b t=%b want v=1 t=%b", codes[i], bus.cond_valid, bus.cond_true, want[i]);
      end
    end
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (bus.cond_valid !== 1'b0 || bus.cond_true !== 1'b0) begin errors++; $display("FAIL valid_drop_hold: got v=%b t=%b want v=0 t=0", bus.cond_valid, bus.cond_true); end
  endtask

  task automatic test_signed_compare();
    logic want [4];
    want = '{1'b0, 1'b1, 1'b0, 1'b1};
    cyc(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'(4'hA + i));
      checks++;
      if (bus.cond_valid !== 1'b1 || bus.cond_true !== want[i]) begin
        errors++;
        $display("FAIL signed_cmp code %h: got v=%b t=%b want v=1 t=%b", 4'(4'hA + i), bus.cond_valid, bus.cond_true, want[i]);
      end
    end
  endtask

  task automatic test_same_edge();
    cyc(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 4'h0);
    checks++; if (bus.cond_true !== 1'b1 || bus.cond_valid !== 1'b1) begin errors++; $display("FAIL same_edge_eval: got v=%b t=%b want v=1 t=1", bus.cond_valid, bus.cond_true); end
    checks++; if (bus.flags !== 4'b0010) begin errors++; $display("FAIL same_edge_flags: got %b want 0010", bus.flags); end
  endtask

  task automatic test_stack_fill();
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 4'h0);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
      checks++;
      if (bus.stack_count !== 3'((i > DEPTH) ? DEPTH : i) || bus.stack_full !== (i >= DEPTH)
          || bus.stack_err !== (i > DEPTH)) begin
        errors++;
        $display("FAIL push %0d: got cnt=%0d full=%b err=%b want cnt=%0d full=%b err=%b", i,
                 bus.stack_count, bus.stack_full, bus.stack_err, (i > DEPTH) ? DEPTH : i, i >= DEPTH, i > DEPTH);
      end
    end
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", bus.stack_err); end
    for (int i = 4; i >= 0; i--) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0);
      checks++;
      if (bus.flags !== 4'((i == 0) ? 1 : i) || bus.stack_err !== (i == 0)
          || bus.stack_count !== 3'((i == 0) ? 0 : i - 1)) begin
        errors++;
        $display("FAIL pop %0d: got flags=%h err=%b cnt=%0d want flags=%h err=%b cnt=%0d", i,
                 bus.flags, bus.stack_err, bus.stack_count, (i == 0) ? 1 : i, i == 0, (i == 0) ? 0 : i - 1);
      end
    end
    checks++; if (bus.stack_empty !== 1'b1) begin errors++; $display("FAIL pop_empty: got %b want 1", bus.stack_empty); end
  endtask

  task automatic test_conflicts();
    cyc(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0);
    checks++;
    if (bus.stack_err !== 1'b1 || bus.stack_count !== 3'd2 || bus.flags !== 4'b0011) begin
      errors++;
      $display("FAIL push_pop: got err=%b cnt=%0d flags=%b want err=1 cnt=2 flags=0011", bus.stack_err, bus.stack_count, bus.flags);
    end
    cyc(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 4'h0);
    checks++;
    if (bus.flags !== 4'b0110 || bus.stack_count !== 3'd3 || bus.stack_err !== 1'b0) begin
      errors++;
      $display("FAIL push_load: got flags=%b cnt=%0d err=%b want flags=0110 cnt=3 err=0", bus.flags, bus.stack_count, bus.stack_err);
    end
    cyc(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4'h0);
    checks++;
    if (bus.flags !== 4'b1001 || bus.stack_count !== 3'd2) begin
      errors++;
      $display("FAIL pop_load: got flags=%b cnt=%0d want flags=1001 cnt=2", bus.flags, bus.stack_count);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 2) == 0), 4'($urandom), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom));
      checks++;
      if (bus.flags !== m_flags || bus.cond_valid !== m_valid || bus.cond_true !== m_true
          || bus.stack_err !== m_err || bus.stack_count !== 3'(m_stack.size())
          || bus.stack_full !== (m_stack.size() == DEPTH) || bus.stack_empty !== (m_stack.size() == 0)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d: got f=%h v=%b t=%b e=%b c=%0d want f=%h v=%b t=%b e=%b c=%0d", n,
                   bus.flags, bus.cond_valid, bus.cond_true, bus.stack_err, bus.stack_count,
                   m_flags, m_valid, m_true, m_err, m_stack.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h5);
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bus.flags !== 4'h0 || bus.stack_empty !== 1'b1 || bus.stack_count !== 3'd0 || bus.cond_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got flags=%h empty=%b cnt=%0d v=%b want 0 1 0 0", bus.flags, bus.stack_empty, bus.stack_count, bus.cond_valid);
    end
    #2 reset = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    checks++; if (bus.cond_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", bus.cond_valid); end
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hE);
    checks++; if (bus.cond_valid !== 1'b1 || bus.cond_true !== 1'b1) begin errors++; $display("FAIL post_reset_al: got v=%b t=%b want 1 1", bus.cond_valid, bus.cond_true); end
  endtask

  initial begin
    test_reset();
    test_load_eval();
    test_signed_compare();
    test_same_edge();
    test_stack_fill();
    test_conflicts();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
Name: ccr_unit

Overview:
- Condition-code register and branch-condition evaluator.
- Consumes the 36-bit flagged ALU result bus, {N, Z, C, V, result[31:0]}, produced by the datapath arithmetic units.
- Holds the current flags and evaluates 16 branch conditions with a registered response.
- Provides a small flag save/restore stack for exception entry and return.

Parameters:
- STACK_DEPTH, 4, number of flag-stack entries (min 1).
- CNT_W, 3, width of stack_count; must hold 0..STACK_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- alu_out  in  36  flagged ALU bus; [35]=N, [34]=Z, [33]=C, [32]=V, [31:0] result (ignored).
- ccr_load  in  1  capture alu_out[35:32] into flags this edge.
- flag_push  in  1  save current flags onto stack.
- flag_pop  in  1  restore flags from stack top.
- cond_req  in  1  evaluate cond_code.
- cond_code  in  4  condition selector.
- flags  out  4  current {N,Z,C,V}.
- cond_valid  out  1  one-cycle pulse; cond_true is valid.
- cond_true  out  1  evaluation result; held until next valid.
- stack_count  out  CNT_W  entries in use.
- stack_full  out  1  stack_count == STACK_DEPTH.
- stack_empty  out  1  stack_count == 0.
- stack_err  out  1  one-cycle pulse on illegal stack op.

Behaviour:
- Clock and reset: single clock, clk. reset is asynchronous, active-high.
- Reset values: flags=0, cond_valid=0, cond_true=0, stack_count=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Reset mid-operation: everything above is forced immediately. Pending evaluations and stack contents are lost. No cond_valid pulse occurs on the edge after reset deasserts unless cond_req is high then.
- Flag update priority per edge: legal pop > ccr_load > hold.
  - Legal pop: flags <= stack top; count-1. A ccr_load in the same cycle is ignored.
  - ccr_load only: flags <= alu_out[35:32].
- Push: stack[count] <= flags (the value before this edge); count+1.
- Push with ccr_load in the same cycle: old flags are saved, new flags are loaded. This is the exception-entry case.
- Errors (each pulses stack_err for one cycle, leaves stack and count unchanged, flags unaffected by the stack):
  - Push when full: dropped; ccr_load still applies.
  - Pop when empty: ccr_load still applies.
  - Push and pop in the same cycle: both dropped; ccr_load still applies.
- stack_full and stack_empty are combinational from the registered count.
- Condition evaluation:
  - Latency: one cycle, registered.
  - At the edge where cond_req=1, cond_true <= f(cond_code, flags pre-edge) and cond_valid <= 1.
  - Otherwise cond_valid <= 0 and cond_true holds.
  - A same-edge load or pop does not affect that evaluation.
  - Back-to-back requests give back-to-back valids.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z & (N==V)
  - D LE: Z | (N!=V)
  - E AL: 1
  - F NV: 0
- X/Z handling: alu_out flag bits that are X/Z are captured as-is. The upstream adder drives its flags to known values even when disabled, so this block adds no masking.

Test Plan:
- Reset then idle: assert reset asynchronously mid-cycle -> flags=0, stack_empty=1 immediately; cond_req with code E next cycle -> cond_valid=1, cond_true=1.
- Load then evaluate: alu_out=36'h4_0000_0000 (Z=1) with ccr_load, then cond_req code 0 -> cond_true=1; code 1 -> 0; code 9 -> 1; code 8 -> 0.
- Signed compare: load N=1,V=0 (alu_out[35:32]=4'b1000), request codes A, B, C, D back-to-back -> cond_true 0, 1, 0, 1 on four consecutive cycles, cond_valid high all four.
- Same-edge ordering: flags=4'b0100, then ccr_load of 4'b0010 with cond_req code 0 in the same cycle -> cond_true=1 (old Z); flags=4'b0010 after the edge.
- Stack fill and overflow: push 5 times, with flags loaded to 1, 2, 3, 4, 5 before each push -> count 1..4, stack_full=1 after the 4th; 5th push -> stack_err pulse, count stays 4. Then pop 4 times -> flags 4, 3, 2, 1; 5th pop -> stack_err, flags=1, stack_empty=1.
- Conflicts: push+pop in the same cycle with count=2 -> stack_err, count=2, flags unchanged. Push+ccr_load (old 4'b1001, new 4'b0110) -> stack top=4'b1001, flags=4'b0110. Pop+ccr_load -> flags=4'b1001 (pop wins).
